// File: rtl/sys_debug_scanner.sv
// Debug sequencer: sweeps output_sel and the register-file test port,
// streams tagged records over valid/ready and watches one register.
module sys_debug_scanner #(
    parameter int SEL_CH   = 8,
    parameter int DWELL    = 4,
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int DATA_W   = 32,
    parameter int LED_W    = 27
) (
    input  logic              SYS_clk,
    input  logic              SYS_reset,
    input  logic              start,
    input  logic              abort,
    input  logic              scan_regs_en,
    output logic [7:0]        SYS_output_sel,
    input  logic [LED_W-1:0]  SYS_leds,
    output logic [REG_AW-1:0] test_address_register,
    input  logic [DATA_W-1:0] test_value_register,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic              rec_kind,
    output logic [7:0]        rec_idx,
    output logic [DATA_W-1:0] rec_data,
    output logic              busy,
    output logic              done,
    input  logic [REG_AW-1:0] watch_addr,
    input  logic [DATA_W-1:0] watch_val,
    output logic              watch_hit,
    input  logic              watch_clr
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]     DW_LAST  = CW'(DWELL - 1);
    localparam logic [7:0]        SEL_LAST = 8'(SEL_CH - 1);
    localparam logic [REG_AW-1:0] REG_LAST = REG_AW'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LED_DWELL,
        LED_EMIT,
        REG_SETTLE,
        REG_EMIT,
        FINISH
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [7:0]          sel_q;
    logic [REG_AW-1:0]   addr_q;
    logic                regs_en_q;
    logic                valid_q;
    logic                kind_q;
    logic [7:0]          idx_q;
    logic [DATA_W-1:0]   data_q;
    logic                busy_q;
    logic                done_q;
    logic                watch_q;
    logic                watch_d;

    // The address register only tracks watch_addr in IDLE, so a stale
    // address right after a scan or a watch_addr change must not hit.
    always_comb begin
        watch_d = watch_q;
        if (state_q == IDLE && addr_q == watch_addr
            && test_value_register == watch_val)
            watch_d = 1'b1;
        if (watch_clr)
            watch_d = 1'b0;
    end

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sel_q     <= '0;
            addr_q    <= '0;
            regs_en_q <= 1'b0;
            valid_q   <= 1'b0;
            kind_q    <= 1'b0;
            idx_q     <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            watch_q   <= 1'b0;
        end else begin
            watch_q <= watch_d;
            done_q  <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        addr_q <= watch_addr;
                        if (start) begin
                            regs_en_q <= scan_regs_en;
                            sel_q     <= '0;
                            cnt_q     <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= LED_DWELL;
                        end
                    end
                    LED_DWELL: begin
                        if (cnt_q == DW_LAST) begin
                            data_q  <= DATA_W'(SYS_leds);
                            kind_q  <= 1'b0;
                            idx_q   <= sel_q;
                            valid_q <= 1'b1;
                            state_q <= LED_EMIT;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    LED_EMIT: begin
                        if (rec_ready) begin
                            valid_q <= 1'b0;
                            if (sel_q != SEL_LAST) begin
                                sel_q   <= sel_q + 8'd1;
                                cnt_q   <= '0;
                                state_q <= LED_DWELL;
                            end else if (regs_en_q) begin
                                addr_q  <= '0;
                                state_q <= REG_SETTLE;
                            end else begin
                                state_q <= FINISH;
                            end
                        end
                    end
                    REG_SETTLE: begin
                        data_q  <= test_value_register;
                        kind_q  <= 1'b1;
                        idx_q   <= 8'(addr_q);
                        valid_q <= 1'b1;
                        state_q <= REG_EMIT;
                    end
                    REG_EMIT: begin
                        if (rec_ready) begin
                            valid_q <= 1'b0;
                            if (addr_q != REG_LAST) begin
                                addr_q  <= addr_q + REG_AW'(1);
                                state_q <= REG_SETTLE;
                            end else begin
                                state_q <= FINISH;
                            end
                        end
                    end
                    FINISH: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign SYS_output_sel        = sel_q;
    assign test_address_register = addr_q;
    assign rec_valid             = valid_q;
    assign rec_kind              = kind_q;
    assign rec_idx               = idx_q;
    assign rec_data              = data_q;
    assign busy                  = busy_q;
    assign done                  = done_q;
    assign watch_hit             = watch_q;

endmodule

// File: tb/tb_sys_debug_scanner.sv
// Directed bench for sys_debug_scanner: LED/register scans,
// backpressure, abort, watch comparator and mid-scan reset.
module tb_sys_debug_scanner;

    logic        clk = 1'b0;
    logic        SYS_reset;
    logic        start;
    logic        abort;
    logic        scan_regs_en;
    logic [7:0]  sel;
    logic [26:0] leds;
    logic [4:0]  taddr;
    logic [31:0] tval;
    logic        rec_valid;
    logic        rec_ready;
    logic        rec_kind;
    logic [7:0]  rec_idx;
    logic [31:0] rec_data;
    logic        busy;
    logic        done;
    logic [4:0]  watch_addr;
    logic [31:0] watch_val;
    logic        watch_hit;
    logic        watch_clr;

    logic [31:0] rf [32];
    logic        r_kind [64];
    logic [7:0]  r_idx  [64];
    logic [31:0] r_data [64];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Processor model: LED mux settles one cycle after output_sel moves.
    always_ff @(posedge clk) leds <= 27'(sel * 3);
    assign tval = rf[taddr];

    sys_debug_scanner dut (
        .SYS_clk              (clk),
        .SYS_reset            (SYS_reset),
        .start                (start),
        .abort                (abort),
        .scan_regs_en         (scan_regs_en),
        .SYS_output_sel       (sel),
        .SYS_leds             (leds),
        .test_address_register(taddr),
        .test_value_register  (tval),
        .rec_valid            (rec_valid),
        .rec_ready            (rec_ready),
        .rec_kind             (rec_kind),
        .rec_idx              (rec_idx),
        .rec_data             (rec_data),
        .busy                 (busy),
        .done                 (done),
        .watch_addr           (watch_addr),
        .watch_val            (watch_val),
        .watch_hit            (watch_hit),
        .watch_clr            (watch_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_scan(input logic regs, output int dcyc,
                            output int n);
        scan_regs_en = regs;
        start = 1'b1;
        tick();
        start = 1'b0;
        scan_regs_en = 1'b0;
        dcyc = -1;
        n = 0;
        for (int c = 1; c <= 400 && dcyc < 0; c++) begin
            if (rec_valid && rec_ready && n < 64) begin
                r_kind[n] = rec_kind;
                r_idx[n]  = rec_idx;
                r_data[n] = rec_data;
                n++;
            end
            tick();
            if (done) dcyc = c;
        end
    endtask

    initial begin
        int dc;
        int nr;
        int seen;
        logic stable;

        for (int i = 0; i < 32; i++) rf[i] = 32'(i + 100);
        SYS_reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        scan_regs_en = 1'b0;
        rec_ready = 1'b1;
        watch_addr = 5'd0;
        watch_val = 32'd0;
        watch_clr = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(rec_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_addr", 32'(taddr), 32'd0);
        chk("rst_idx", 32'(rec_idx), 32'd0);
        chk("rst_data", rec_data, 32'd0);
        chk("rst_watch", 32'(watch_hit), 32'd0);
        SYS_reset = 1'b0;
        tick();

        // LED-only scan
        run_scan(1'b0, dc, nr);
        chk("led_done_cyc", 32'(dc), 32'd41);
        chk("led_nrec", 32'(nr), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("led_kind", 32'(r_kind[i]), 32'd0);
            chk("led_idx", 32'(r_idx[i]), 32'(i));
            chk("led_data", r_data[i], 32'(3 * i));
        end
        tick();
        chk("led_done_pulse", 32'(done), 32'd0);
        chk("led_busy_end", 32'(busy), 32'd0);

        // Full LED + register scan
        run_scan(1'b1, dc, nr);
        chk("full_done_cyc", 32'(dc), 32'd105);
        chk("full_nrec", 32'(nr), 32'd40);
        for (int i = 0; i < 32; i++) begin
            chk("reg_kind", 32'(r_kind[8 + i]), 32'd1);
            chk("reg_idx", 32'(r_idx[8 + i]), 32'(i));
            chk("reg_data", r_data[8 + i], 32'(100 + i));
        end
        tick();

        // Backpressure on record idx 2
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("bp_busy", 32'(busy), 32'd1);
        seen = 0;
        for (int c = 0; c < 100 && seen == 0; c++) begin
            if (rec_valid && rec_idx == 8'd2) seen = 1;
            else tick();
        end
        chk("bp_reach_idx2", 32'(seen), 32'd1);
        rec_ready = 1'b0;
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (!(rec_valid === 1'b1 && rec_idx === 8'd2
                  && rec_data === 32'd6 && sel === 8'd2))
                stable = 1'b0;
        end
        chk("bp_stable", 32'(stable), 32'd1);
        rec_ready = 1'b1;
        tick();
        chk("bp_valid_drop", 32'(rec_valid), 32'd0);
        chk("bp_sel_next", 32'(sel), 32'd3);
        for (int c = 0; c < 4; c++) tick();
        chk("bp_rec3_valid", 32'(rec_valid), 32'd1);
        chk("bp_rec3_idx", 32'(rec_idx), 32'd3);
        chk("bp_rec3_data", rec_data, 32'd9);
        seen = 0;
        for (int c = 0; c < 100 && seen == 0; c++) begin
            tick();
            if (done) seen = 1;
        end
        chk("bp_done", 32'(seen), 32'd1);
        tick();

        // Abort in REG_EMIT at address 5
        scan_regs_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        scan_regs_en = 1'b0;
        seen = 0;
        for (int c = 0; c < 200 && seen == 0; c++) begin
            if (rec_valid && rec_kind && rec_idx == 8'd5) seen = 1;
            else tick();
        end
        chk("ab_reach_reg5", 32'(seen), 32'd1);
        rec_ready = 1'b0;
        tick();
        tick();
        chk("ab_hold", 32'(rec_valid), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        rec_ready = 1'b1;
        chk("ab_valid", 32'(rec_valid), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        tick();
        chk("ab_done2", 32'(done), 32'd0);
        chk("ab_valid2", 32'(rec_valid), 32'd0);
        run_scan(1'b0, dc, nr);
        chk("ab_rescan_cyc", 32'(dc), 32'd41);
        chk("ab_rescan_idx0", 32'(r_idx[0]), 32'd0);
        chk("ab_rescan_n", 32'(nr), 32'd8);
        tick();

        // Watch comparator
        watch_addr = 5'd8;
        watch_val = 32'd55;
        tick();
        chk("w_addr", 32'(taddr), 32'd8);
        chk("w_nohit", 32'(watch_hit), 32'd0);
        rf[8] = 32'd55;
        #1;
        chk("w_not_yet", 32'(watch_hit), 32'd0);
        tick();
        chk("w_hit", 32'(watch_hit), 32'd1);
        rf[8] = 32'd108;
        run_scan(1'b1, dc, nr);
        chk("w_scan_cyc", 32'(dc), 32'd105);
        chk("w_scan_r8", r_data[16], 32'd108);
        chk("w_persist", 32'(watch_hit), 32'd1);
        tick();
        tick();
        rf[8] = 32'd55;
        watch_clr = 1'b1;
        tick();
        chk("w_clr_wins", 32'(watch_hit), 32'd0);
        watch_clr = 1'b0;
        tick();
        chk("w_reset_again", 32'(watch_hit), 32'd1);
        rf[8] = 32'd108;

        // Reset during LED_DWELL with sel=3
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 100 && seen == 0; c++) begin
            if (!rec_valid && sel == 8'd3) seen = 1;
            else tick();
        end
        chk("mr_reach_sel3", 32'(seen), 32'd1);
        SYS_reset = 1'b1;
        tick();
        chk("mr_sel", 32'(sel), 32'd0);
        chk("mr_valid", 32'(rec_valid), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_done", 32'(done), 32'd0);
        chk("mr_watch", 32'(watch_hit), 32'd0);
        chk("mr_data", rec_data, 32'd0);
        SYS_reset = 1'b0;
        tick();
        chk("mr_done2", 32'(done), 32'd0);
        chk("mr_busy2", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
